// File: rtl/simd_issue_ctrl_pkg.sv
// simd_issue_ctrl_pkg
// Shared types and helpers for the packed-SIMD issue controller:
//   RV_XLEN        - default datapath width
//   TRANS_ID_BITS  - scoreboard tag width
//   fu_op          - decoded SIMD operation (ALU class and multiply class)
//   simd_class_e   - functional-unit class of an op
//   inflight_t     - one entry of the multiplier in-flight FIFO
//   is_simd_mul()  - true for the multiply-class ops
package simd_issue_ctrl_pkg;

  localparam int unsigned RV_XLEN       = 32;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    ADD16    = 4'd0,
    SUB16    = 4'd1,
    RADD16   = 4'd2,
    URADD16  = 4'd3,
    KADD16   = 4'd4,
    UKADD16  = 4'd5,
    KSUB16   = 4'd6,
    UKSUB16  = 4'd7,
    CRAS16   = 4'd8,
    CRSA16   = 4'd9,
    KSTAS16  = 4'd10,
    UKSTSA16 = 4'd11,
    SMUL8    = 4'd12,
    UMUL8    = 4'd13
  } fu_op;

  typedef enum logic {
    SIMD_ALU = 1'b0,
    SIMD_MUL = 1'b1
  } simd_class_e;

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } inflight_t;

  function automatic logic is_simd_mul(input fu_op op);
    return (op == SMUL8) || (op == UMUL8);
  endfunction

endpackage

// File: rtl/simd_issue_ctrl_if.sv
// simd_issue_ctrl_if
// Issue-side handshake and writeback beat of the SIMD issue controller.
//   simd_valid_i / simd_op_i / operand_a_i / operand_b_i / trans_id_i : op from issue
//   simd_ready_o                                                       : op can be accepted
//   result_valid_o / result_o / trans_id_o / wb_hi_o                   : writeback beat
// master = issue stage / scoreboard side, slave = the controller.
interface simd_issue_ctrl_if #(
  parameter int unsigned XLEN = simd_issue_ctrl_pkg::RV_XLEN
);
  import simd_issue_ctrl_pkg::*;

  logic                     simd_valid_i;
  fu_op                     simd_op_i;
  logic [XLEN-1:0]          operand_a_i;
  logic [XLEN-1:0]          operand_b_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic                     simd_ready_o;

  logic                     result_valid_o;
  logic [XLEN-1:0]          result_o;
  logic [TRANS_ID_BITS-1:0] trans_id_o;
  logic                     wb_hi_o;

  modport master (
    output simd_valid_i, simd_op_i, operand_a_i, operand_b_i, trans_id_i,
    input  simd_ready_o, result_valid_o, result_o, trans_id_o, wb_hi_o
  );

  modport slave (
    input  simd_valid_i, simd_op_i, operand_a_i, operand_b_i, trans_id_i,
    output simd_ready_o, result_valid_o, result_o, trans_id_o, wb_hi_o
  );

endinterface

// File: rtl/simd_wb_slots.sv
// simd_wb_slots
// Reservation shift register for the shared writeback port.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drops every reservation
//   set_mask   : reservations made by the op accepted this cycle
//   slots      : bit k set = writeback port busy k cycles from now
module simd_wb_slots #(
  parameter int unsigned Depth = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic [Depth:1] set_mask,
  output logic [Depth:1] slots
);

  logic [Depth:1] merged;

  // New reservations are relative to the current cycle, so they are merged
  // before the shift; bit 1 falls off because that cycle has now arrived.
  assign merged = slots | set_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots <= '0;
    end else if (flush) begin
      slots <= '0;
    end else begin
      slots <= merged >> 1;
    end
  end

endmodule

// File: rtl/simd_issue_ctrl.sv
// simd_issue_ctrl
// Sequences packed-SIMD ops from issue to the single-cycle SIMD ALU or the
// pipelined SIMD multiplier and schedules their results onto one writeback
// port. Multiply results (2*XLEN) go back as a low beat then a high beat.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   flush_i                  : kill everything not yet written back
//   issue (slave)            : issue handshake and writeback beat
//   alu_op_o/alu_a_o/alu_b_o : ALU request, alu_result_i same-cycle result
//   mul_valid_o/mul_op_o/mul_a_o/mul_b_o : multiplier request
//   mul_valid_i/mul_result_i : multiplier result, MulLatency cycles later
module simd_issue_ctrl
  import simd_issue_ctrl_pkg::*;
#(
  parameter int unsigned MulLatency = 2,
  parameter int unsigned XLEN       = RV_XLEN
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  simd_issue_ctrl_if.slave    issue,
  output fu_op                alu_op_o,
  output logic [XLEN-1:0]     alu_a_o,
  output logic [XLEN-1:0]     alu_b_o,
  input  logic [XLEN-1:0]     alu_result_i,
  output logic                mul_valid_o,
  output fu_op                mul_op_o,
  output logic [XLEN-1:0]     mul_a_o,
  output logic [XLEN-1:0]     mul_b_o,
  input  logic                mul_valid_i,
  input  logic [2*XLEN-1:0]   mul_result_i
);

  localparam int unsigned SlotW = MulLatency + 1;
  localparam int unsigned PtrW  = (MulLatency > 1) ? $clog2(MulLatency) : 1;
  localparam int unsigned CntW  = $clog2(MulLatency + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MulLatency - 1);

  simd_class_e              op_class;
  logic                     ready;
  logic                     alu_accept;
  logic                     mul_accept;
  logic [SlotW:1]           slot_q;
  logic [SlotW:1]           set_mask;

  logic                     alu_wb_valid_q;
  logic [XLEN-1:0]          alu_wb_data_q;
  logic [TRANS_ID_BITS-1:0] alu_wb_id_q;

  inflight_t                fifo_q [MulLatency];
  logic [PtrW-1:0]          wr_ptr_q;
  logic [PtrW-1:0]          rd_ptr_q;
  logic [CntW-1:0]          cnt_q;
  inflight_t                head;
  logic                     fifo_nonempty;
  logic                     pop;
  logic                     lo_fire;

  logic                     hi_valid_q;
  logic [XLEN-1:0]          hi_data_q;
  logic [TRANS_ID_BITS-1:0] hi_id_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign op_class = is_simd_mul(issue.simd_op_i) ? SIMD_MUL : SIMD_ALU;

  // Readiness looks only at the op and the reservations, never at valid,
  // so the issue stage can use it to decide whether to present the op.
  // A multiply claims two consecutive beats, hence two slots to check.
  always_comb begin
    if (op_class == SIMD_MUL) begin
      ready = !slot_q[MulLatency] && !slot_q[MulLatency+1];
    end else begin
      ready = !slot_q[1];
    end
    ready = ready && !flush_i;
  end

  assign issue.simd_ready_o = ready;
  assign alu_accept = issue.simd_valid_i && ready && (op_class == SIMD_ALU);
  assign mul_accept = issue.simd_valid_i && ready && (op_class == SIMD_MUL);

  always_comb begin
    set_mask = '0;
    if (alu_accept) begin
      set_mask[1] = 1'b1;
    end
    if (mul_accept) begin
      set_mask[MulLatency]   = 1'b1;
      set_mask[MulLatency+1] = 1'b1;
    end
  end

  simd_wb_slots #(
    .Depth (SlotW)
  ) u_slots (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .flush    (flush_i),
    .set_mask (set_mask),
    .slots    (slot_q)
  );

  // Functional-unit requests are quiet (all zero) unless the op is accepted.
  assign alu_op_o    = alu_accept ? issue.simd_op_i   : ADD16;
  assign alu_a_o     = alu_accept ? issue.operand_a_i : '0;
  assign alu_b_o     = alu_accept ? issue.operand_b_i : '0;
  assign mul_valid_o = mul_accept;
  assign mul_op_o    = mul_accept ? issue.simd_op_i   : ADD16;
  assign mul_a_o     = mul_accept ? issue.operand_a_i : '0;
  assign mul_b_o     = mul_accept ? issue.operand_b_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_wb_valid_q <= 1'b0;
      alu_wb_data_q  <= '0;
      alu_wb_id_q    <= '0;
    end else begin
      alu_wb_valid_q <= alu_accept;
      if (alu_accept) begin
        alu_wb_data_q <= alu_result_i;
        alu_wb_id_q   <= issue.trans_id_i;
      end
    end
  end

  // The multiplier returns in issue order, so the FIFO head always belongs
  // to the result arriving now. Flush only clears valid bits: the killed
  // results still come back and must pop their own entries.
  assign head          = fifo_q[rd_ptr_q];
  assign fifo_nonempty = (cnt_q != '0);
  assign pop           = mul_valid_i && fifo_nonempty;
  assign lo_fire       = pop && head.valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MulLatency); i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < int'(MulLatency); i++) begin
          fifo_q[i].valid <= 1'b0;
        end
      end
      if (mul_accept) begin
        fifo_q[wr_ptr_q] <= '{valid: 1'b1, trans_id: issue.trans_id_i};
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({mul_accept, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // High word waits one cycle here; its slot was reserved at accept time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_valid_q <= 1'b0;
      hi_data_q  <= '0;
      hi_id_q    <= '0;
    end else begin
      hi_valid_q <= lo_fire && !flush_i;
      if (lo_fire) begin
        hi_data_q <= mul_result_i[2*XLEN-1:XLEN];
        hi_id_q   <= head.trans_id;
      end
    end
  end

  // At most one source is live thanks to the reservations; a beat that
  // would go out in a flush cycle is killed along with everything else.
  always_comb begin
    issue.result_valid_o = 1'b0;
    issue.result_o       = '0;
    issue.trans_id_o     = '0;
    issue.wb_hi_o        = 1'b0;
    if (!flush_i) begin
      if (alu_wb_valid_q) begin
        issue.result_valid_o = 1'b1;
        issue.result_o       = alu_wb_data_q;
        issue.trans_id_o     = alu_wb_id_q;
      end else if (lo_fire) begin
        issue.result_valid_o = 1'b1;
        issue.result_o       = mul_result_i[XLEN-1:0];
        issue.trans_id_o     = head.trans_id;
      end else if (hi_valid_q) begin
        issue.result_valid_o = 1'b1;
        issue.result_o       = hi_data_q;
        issue.trans_id_o     = hi_id_q;
        issue.wb_hi_o        = 1'b1;
      end
    end
  end

  wb_single_beat: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({alu_wb_valid_q, lo_fire, hi_valid_q}));

  no_orphan_return: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mul_valid_i |-> fifo_nonempty);

endmodule
